// File: rtl/dht11_uart_reporter.sv
// Formats DHT11 measurement results as ASCII lines and streams them byte by byte
// to a UART transmitter, with a one-deep pending buffer and a busy-rise timeout.
module dht11_uart_reporter #(
   parameter logic [7:0]  TEMP_UNIT_CHAR = 8'h43,
   parameter int unsigned BUSY_TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dht_done,
   input  logic        valid,
   input  logic [31:0] dht_data,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        report_busy,
   output logic [7:0]  overrun_cnt,
   output logic        abort_flag
);

   localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StLatch, StConv, StSend, StWaitHi, StWaitLo} state_e;

   state_e          state_q, state_d;
   logic            pend_full_q, pend_full_d;
   logic [32:0]     pend_data_q, pend_data_d;
   logic [32:0]     lat_q, lat_d;
   logic            is_err_q, is_err_d;
   logic [6:0]      rh_rem_q, rh_rem_d, t_rem_q, t_rem_d;
   logic [3:0]      rh_ten_q, rh_ten_d, t_ten_q, t_ten_d;
   logic [3:0]      rh_dec_q, rh_dec_d, t_dec_q, t_dec_d;
   logic [4:0]      idx_q, idx_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [7:0]      ovr_q, ovr_d;
   logic            abort_q, abort_d;
   logic [7:0]      cur_byte;
   logic [4:0]      last_idx;
   logic            direct, consume;

   function automatic logic [6:0] sat_int(input logic [7:0] v);
      return (v > 8'd99) ? 7'd99 : v[6:0];
   endfunction

   function automatic logic [3:0] sat_dec(input logic [7:0] v);
      return (v > 8'd9) ? 4'd9 : v[3:0];
   endfunction

   function automatic logic [7:0] digit(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   assign last_idx = is_err_q ? 5'd4 : 5'd17;

   always_comb begin
      cur_byte = 8'h00;
      if (is_err_q) begin
         case (idx_q)
            5'd0:    cur_byte = 8'h45;
            5'd1:    cur_byte = 8'h52;
            5'd2:    cur_byte = 8'h52;
            5'd3:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
         endcase
      end else begin
         case (idx_q)
            5'd0:    cur_byte = 8'h52;
            5'd1:    cur_byte = 8'h48;
            5'd2:    cur_byte = 8'h3D;
            5'd3:    cur_byte = digit(rh_ten_q);
            5'd4:    cur_byte = digit(rh_rem_q[3:0]);
            5'd5:    cur_byte = 8'h2E;
            5'd6:    cur_byte = digit(rh_dec_q);
            5'd7:    cur_byte = 8'h25;
            5'd8:    cur_byte = 8'h20;
            5'd9:    cur_byte = 8'h54;
            5'd10:   cur_byte = 8'h3D;
            5'd11:   cur_byte = digit(t_ten_q);
            5'd12:   cur_byte = digit(t_rem_q[3:0]);
            5'd13:   cur_byte = 8'h2E;
            5'd14:   cur_byte = digit(t_dec_q);
            5'd15:   cur_byte = TEMP_UNIT_CHAR;
            5'd16:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_full_d = pend_full_q;
      pend_data_d = pend_data_q;
      lat_d       = lat_q;
      is_err_d    = is_err_q;
      rh_rem_d    = rh_rem_q;
      rh_ten_d    = rh_ten_q;
      rh_dec_d    = rh_dec_q;
      t_rem_d     = t_rem_q;
      t_ten_d     = t_ten_q;
      t_dec_d     = t_dec_q;
      idx_d       = idx_q;
      to_cnt_d    = to_cnt_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      ovr_d       = ovr_q;
      abort_d     = abort_q;

      direct  = dht_done && (state_q == StIdle) && !pend_full_q;
      consume = (state_q == StIdle) && pend_full_q;

      // A capture coinciding with a consume lands in the freshly emptied slot.
      if (consume) pend_full_d = 1'b0;
      if (dht_done && !direct) begin
         pend_data_d = {valid, dht_data};
         pend_full_d = 1'b1;
         if (pend_full_q && !consume && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (direct) begin
               lat_d   = {valid, dht_data};
               state_d = StLatch;
            end else if (consume) begin
               lat_d   = pend_data_q;
               state_d = StLatch;
            end
         end
         StLatch: begin
            idx_d    = 5'd0;
            is_err_d = !lat_q[32];
            rh_rem_d = sat_int(lat_q[31:24]);
            rh_dec_d = sat_dec(lat_q[23:16]);
            t_rem_d  = sat_int(lat_q[15:8]);
            t_dec_d  = sat_dec(lat_q[7:0]);
            rh_ten_d = 4'd0;
            t_ten_d  = 4'd0;
            state_d  = lat_q[32] ? StConv : StSend;
         end
         StConv: begin
            if (rh_rem_q >= 7'd10) begin
               rh_rem_d = rh_rem_q - 7'd10;
               rh_ten_d = rh_ten_q + 4'd1;
            end else if (t_rem_q >= 7'd10) begin
               t_rem_d = t_rem_q - 7'd10;
               t_ten_d = t_ten_q + 4'd1;
            end else begin
               state_d = StSend;
            end
         end
         StSend: begin
            tx_data_d = cur_byte;
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = StWaitHi;
            end
         end
         StWaitHi: begin
            if (tx_busy) begin
               state_d = StWaitLo;
            end else if (to_cnt_q == TO_LAST) begin
               abort_d = 1'b1;
               state_d = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StWaitLo: begin
            if (!tx_busy) begin
               if (idx_q == last_idx) begin
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StSend;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pend_full_q <= 1'b0;
         pend_data_q <= '0;
         lat_q       <= '0;
         is_err_q    <= 1'b0;
         rh_rem_q    <= '0;
         rh_ten_q    <= '0;
         rh_dec_q    <= '0;
         t_rem_q     <= '0;
         t_ten_q     <= '0;
         t_dec_q     <= '0;
         idx_q       <= '0;
         to_cnt_q    <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         ovr_q       <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_full_q <= pend_full_d;
         pend_data_q <= pend_data_d;
         lat_q       <= lat_d;
         is_err_q    <= is_err_d;
         rh_rem_q    <= rh_rem_d;
         rh_ten_q    <= rh_ten_d;
         rh_dec_q    <= rh_dec_d;
         t_rem_q     <= t_rem_d;
         t_ten_q     <= t_ten_d;
         t_dec_q     <= t_dec_d;
         idx_q       <= idx_d;
         to_cnt_q    <= to_cnt_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         ovr_q       <= ovr_d;
         abort_q     <= abort_d;
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign report_busy = (state_q != StIdle);
   assign overrun_cnt = ovr_q;
   assign abort_flag  = abort_q;

endmodule
